// File: rtl/inst_dispatch_ctrl.sv
// Instruction dispatch controller: fetches 128-bit instructions one at a time and
// issues each to Mover1, Mover2 or TPU under per-target occupancy and barrier rules.
module inst_dispatch_ctrl #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned INST_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              CAN_READ_INST,
  input  logic [ADDR_W-1:0] BASE_ADDR,
  output logic              RD_START,
  output logic [ADDR_W-1:0] RD_ADDR,
  input  logic [INST_W-1:0] RD_DATA,
  input  logic              RD_DONE,
  output logic              o_drive2Mover1,
  output logic              o_drive2Mover2,
  output logic              o_drive2TPU,
  output logic [INST_W-1:0] o_data2Mover1,
  output logic [INST_W-1:0] o_data2Mover2,
  output logic [INST_W-1:0] o_data2TPU,
  input  logic              i_freeF_Mover1,
  input  logic              i_freeF_Mover2,
  input  logic              i_freeFTPU,
  output logic              FINISH,
  output logic              STATUS_ERR,
  output logic [15:0]       STATUS_CNT
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned NTGT  = 3;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_FETCH    = 3'd1;
  localparam logic [2:0] S_WAITRD   = 3'd2;
  localparam logic [2:0] S_DISPATCH = 3'd3;
  localparam logic [2:0] S_DRAIN    = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  localparam logic [3:0] OP_END = 4'h0;
  localparam logic [3:0] OP_M1  = 4'h1;
  localparam logic [3:0] OP_M2  = 4'h2;
  localparam logic [3:0] OP_TPU = 4'h3;
  localparam logic [3:0] OP_NOP = 4'hF;

  logic [2:0]        state, state_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt, rd_addr_nxt;
  logic [INST_W-1:0] inst_reg, inst_nxt;
  logic [NTGT-1:0]   busy, busy_nxt, drive, drive_nxt, frees, tgt_mask;
  logic [INST_W-1:0] payload [NTGT];
  logic [INST_W-1:0] payload_nxt [NTGT];
  logic              rd_start_nxt, finish_nxt, err_nxt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [3:0]        opcode;
  logic              barrier;

  // Bit order everywhere: [0]=Mover1, [1]=Mover2, [2]=TPU
  assign frees   = {i_freeFTPU, i_freeF_Mover2, i_freeF_Mover1};
  assign opcode  = inst_reg[INST_W-1 -: 4];
  assign barrier = inst_reg[INST_W-5];

  assign o_drive2Mover1 = drive[0];
  assign o_drive2Mover2 = drive[1];
  assign o_drive2TPU    = drive[2];
  assign o_data2Mover1  = payload[0];
  assign o_data2Mover2  = payload[1];
  assign o_data2TPU     = payload[2];

  // Decode target opcode to a one-hot mask; zero for END/NOP/illegal
  always_comb begin
    tgt_mask = 3'b000;
    case (opcode)
      OP_M1:   tgt_mask = 3'b001;
      OP_M2:   tgt_mask = 3'b010;
      OP_TPU:  tgt_mask = 3'b100;
      default: tgt_mask = 3'b000;
    endcase
  end

  // Next-state and registered-output values
  always_comb begin
    state_nxt    = state;
    addr_nxt     = addr;
    rd_addr_nxt  = RD_ADDR;
    inst_nxt     = inst_reg;
    rd_start_nxt = 1'b0;
    drive_nxt    = '0;
    finish_nxt   = FINISH;
    cnt_nxt      = STATUS_CNT;
    for (int i = 0; i < NTGT; i++) payload_nxt[i] = payload[i];
    // A free for an idle target is dropped but flagged
    busy_nxt = busy & ~frees;
    err_nxt  = STATUS_ERR | (|(frees & ~busy));

    case (state)
      S_IDLE: begin
        if (CAN_READ_INST) begin
          addr_nxt  = BASE_ADDR;
          state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        rd_start_nxt = 1'b1;
        rd_addr_nxt  = addr;
        state_nxt    = S_WAITRD;
      end
      S_WAITRD: begin
        if (RD_DONE) begin
          inst_nxt  = RD_DATA;
          state_nxt = S_DISPATCH;
        end
      end
      S_DISPATCH: begin
        if (opcode == OP_END) begin
          state_nxt = S_DRAIN;
        end else if (tgt_mask != 3'b000) begin
          if (((busy & tgt_mask) == 3'b000) && !(barrier && (|busy))) begin
            drive_nxt = tgt_mask;
            busy_nxt  = busy_nxt | tgt_mask;
            for (int i = 0; i < NTGT; i++)
              if (tgt_mask[i]) payload_nxt[i] = inst_reg;
            if (STATUS_CNT != {CNT_W{1'b1}}) cnt_nxt = STATUS_CNT + 1'b1;
            addr_nxt  = addr + 1'b1;
            state_nxt = S_FETCH;
          end
        end else begin
          if (opcode != OP_NOP) err_nxt = 1'b1;
          addr_nxt  = addr + 1'b1;
          state_nxt = S_FETCH;
        end
      end
      S_DRAIN: begin
        if (busy == 3'b000) begin
          finish_nxt = 1'b1;
          state_nxt  = S_DONE;
        end
      end
      S_DONE: begin
        if (!CAN_READ_INST) begin
          finish_nxt = 1'b0;
          state_nxt  = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      addr       <= '0;
      inst_reg   <= '0;
      busy       <= '0;
      drive      <= '0;
      RD_START   <= 1'b0;
      RD_ADDR    <= '0;
      FINISH     <= 1'b0;
      STATUS_ERR <= 1'b0;
      STATUS_CNT <= '0;
      for (int i = 0; i < NTGT; i++) payload[i] <= '0;
    end else begin
      state      <= state_nxt;
      addr       <= addr_nxt;
      inst_reg   <= inst_nxt;
      busy       <= busy_nxt;
      drive      <= drive_nxt;
      RD_START   <= rd_start_nxt;
      RD_ADDR    <= rd_addr_nxt;
      FINISH     <= finish_nxt;
      STATUS_ERR <= err_nxt;
      STATUS_CNT <= cnt_nxt;
      for (int i = 0; i < NTGT; i++) payload[i] <= payload_nxt[i];
    end
  end

endmodule

// File: tb/tb_inst_dispatch_ctrl.sv
// Bench for inst_dispatch_ctrl: BRAM and target responders, dispatch scoreboard,
// a table of single-instruction programs and hand-written multi-cycle sequences.
module tb_inst_dispatch_ctrl;

  logic         clk = 1'b0;
  logic         rst, can;
  logic [7:0]   base_addr;
  logic         rd_start;
  logic [7:0]   rd_addr;
  logic [127:0] rd_data = '0;
  logic         rd_done = 1'b0;
  logic         drv_m1, drv_m2, drv_tpu;
  logic [127:0] d_m1, d_m2, d_tpu;
  logic [2:0]   frees = 3'b000;
  logic         finish, err;
  logic [15:0]  cnt;
  logic [2:0]   drv;

  always #5 clk = ~clk;
  assign drv = {drv_tpu, drv_m2, drv_m1};

  inst_dispatch_ctrl #(.ADDR_W(8), .INST_W(128)) dut (
    .clk(clk), .rst(rst), .CAN_READ_INST(can), .BASE_ADDR(base_addr),
    .RD_START(rd_start), .RD_ADDR(rd_addr), .RD_DATA(rd_data), .RD_DONE(rd_done),
    .o_drive2Mover1(drv_m1), .o_drive2Mover2(drv_m2), .o_drive2TPU(drv_tpu),
    .o_data2Mover1(d_m1), .o_data2Mover2(d_m2), .o_data2TPU(d_tpu),
    .i_freeF_Mover1(frees[0]), .i_freeF_Mover2(frees[1]), .i_freeFTPU(frees[2]),
    .FINISH(finish), .STATUS_ERR(err), .STATUS_CNT(cnt)
  );

  typedef struct { int tgt; logic [127:0] data; } exp_t;
  typedef struct { int tgt; int cyc; } ev_t;
  typedef struct { int cyc; logic [7:0] addr; } rd_t;
  typedef struct {
    logic [127:0] inst; logic [7:0] base; int tgt; logic exp_err; logic [15:0] exp_cnt;
  } vec_t;

  exp_t exp_q[$];
  ev_t  drv_log[$];
  rd_t  rd_log[$];
  int   done_log[$];
  logic [127:0] mem [256];
  vec_t vecs [6];

  int nvec = 0, nerr = 0;
  int cyc = 0, can_edge = 0, fin_cyc = 0;
  int fc [3] = '{0, 0, 0};
  int flat [3] = '{3, 3, 3};
  int free_edge [3] = '{0, 0, 0};
  logic [2:0] auto_free = 3'b111;
  logic [2:0] spur = 3'b000;
  logic       rd_pend = 1'b0;
  logic [7:0] rd_a = '0;
  int d, d2, t, nwin;
  logic [127:0] w0, w1, w2, w3;
  logic [7:0] b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic logic [127:0] mk(input logic [3:0] op, input logic b);
    logic [127:0] w;
    w = {$urandom(), $urandom(), $urandom(), $urandom()};
    w[127:124] = op;
    w[123] = b;
    return w;
  endfunction

  function automatic logic [127:0] data_of(input int i);
    if (i == 0) return d_m1;
    if (i == 1) return d_m2;
    return d_tpu;
  endfunction

  function automatic int drive_cyc(input int tgt, input int n);
    int k = 0;
    foreach (drv_log[j]) begin
      if (drv_log[j].tgt == tgt) begin
        if (k == n) return drv_log[j].cyc;
        k++;
      end
    end
    return -1;
  endfunction

  // BRAM model: one-cycle turnaround after each RD_START
  always @(negedge clk) begin
    rd_done = 1'b0;
    if (rst) rd_pend = 1'b0;
    else begin
      if (rd_pend) begin
        rd_done = 1'b1;
        rd_data = mem[rd_a];
        rd_pend = 1'b0;
        done_log.push_back(cyc + 1);
      end
      if (rd_start) begin
        rd_pend = 1'b1;
        rd_a = rd_addr;
        rd_log.push_back('{cyc, rd_addr});
      end
    end
  end

  // Target model: free pulse sampled flat[i] edges after the drive edge
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      frees[i] = spur[i];
      spur[i] = 1'b0;
      if (fc[i] > 0) begin
        fc[i]--;
        if (fc[i] == 0) begin
          frees[i] = 1'b1;
          free_edge[i] = cyc + 1;
        end
      end
      if (drv[i] && !rst && auto_free[i]) fc[i] = flat[i] - 1;
      if (rst) begin
        fc[i] = 0;
        frees[i] = spur[i];
      end
    end
  end

  // Scoreboard: every drive pops the next expected dispatch
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        if (drv[i]) begin
          drv_log.push_back('{i, cyc});
          if (exp_q.size() == 0) begin
            nvec++;
            nerr++;
            $display("FAIL unexpected_drive: target %0d at cycle %0d, none required", i, cyc);
          end else begin
            e = exp_q.pop_front();
            check("drive_target", 128'(i), 128'(e.tgt));
            check("drive_data", data_of(i), e.data);
          end
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    can = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    drv_log.delete();
    rd_log.delete();
    done_log.delete();
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_rd_start"}, 128'(rd_start), 128'(0));
    check({tag, "_rd_addr"},  128'(rd_addr), 128'(0));
    check({tag, "_drives"},   128'(drv), 128'(0));
    check({tag, "_finish"},   128'(finish), 128'(0));
    check({tag, "_err"},      128'(err), 128'(0));
    check({tag, "_cnt"},      128'(cnt), 128'(0));
    check({tag, "_data"},     d_m1 | d_m2 | d_tpu, 128'(0));
  endtask

  task automatic start(input logic [7:0] b);
    base_addr = b;
    can = 1'b1;
    can_edge = cyc + 1;
  endtask

  task automatic wait_finish(input string name, input int maxc);
    int n = 0;
    while (!finish && n < maxc) begin
      @(negedge clk);
      n++;
    end
    fin_cyc = cyc;
    check(name, 128'(finish), 128'(1));
  endtask

  task automatic stop();
    int n = 0;
    can = 1'b0;
    while (finish && n < 5) begin
      @(negedge clk);
      n++;
    end
    check("finish_release", 128'(finish), 128'(0));
  endtask

  task automatic push(input int tgt, input logic [127:0] w);
    exp_q.push_back('{tgt, w});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    can = 1'b0;
    base_addr = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    vecs[0] = '{inst: mk(4'h1, 1'b0), base: 8'h10, tgt: 0,  exp_err: 1'b0, exp_cnt: 16'd1};
    vecs[1] = '{inst: mk(4'h2, 1'b0), base: 8'h20, tgt: 1,  exp_err: 1'b0, exp_cnt: 16'd1};
    vecs[2] = '{inst: mk(4'h3, 1'b1), base: 8'h30, tgt: 2,  exp_err: 1'b0, exp_cnt: 16'd1};
    vecs[3] = '{inst: mk(4'hF, 1'b0), base: 8'h40, tgt: -1, exp_err: 1'b0, exp_cnt: 16'd0};
    vecs[4] = '{inst: mk(4'h7, 1'b0), base: 8'h50, tgt: -1, exp_err: 1'b1, exp_cnt: 16'd0};
    vecs[5] = '{inst: mk(4'hE, 1'b1), base: 8'h60, tgt: -1, exp_err: 1'b1, exp_cnt: 16'd0};

    repeat (3) @(negedge clk);
    check_reset("por");
    rst = 1'b0;

    // Single instruction followed by END, one program per table row
    for (int v = 0; v < 6; v++) begin
      do_reset();
      b1 = vecs[v].base + 8'd1;
      mem[vecs[v].base] = vecs[v].inst;
      mem[b1] = mk(4'h0, 1'b0);
      if (vecs[v].tgt >= 0) push(vecs[v].tgt, vecs[v].inst);
      start(vecs[v].base);
      wait_finish("vec_finish", 200);
      check("vec_cnt", 128'(cnt), 128'(vecs[v].exp_cnt));
      check("vec_err", 128'(err), 128'(vecs[v].exp_err));
      check("vec_sb_empty", 128'(exp_q.size()), 128'(0));
      check("vec_reads", 128'(rd_log.size()), 128'(2));
      stop();
    end

    // Three-target sequence with fixed latency relations
    do_reset();
    w0 = mk(4'h1, 1'b0); w1 = mk(4'h2, 1'b0); w2 = mk(4'h3, 1'b0); w3 = mk(4'h0, 1'b0);
    mem[0] = w0; mem[1] = w1; mem[2] = w2; mem[3] = w3;
    push(0, w0); push(1, w1); push(2, w2);
    start(8'h00);
    wait_finish("t1_finish", 200);
    check("t1_cnt", 128'(cnt), 128'(3));
    check("t1_err", 128'(err), 128'(0));
    check("t1_sb_empty", 128'(exp_q.size()), 128'(0));
    check("t1_rdstart_lat", 128'(rd_log.size() > 0 ? rd_log[0].cyc : -1), 128'(can_edge + 1));
    check("t1_drive_lat", 128'(drive_cyc(0, 0)), 128'(done_log.size() > 0 ? done_log[0] + 1 : -2));
    check("t1_next_fetch", 128'(rd_log.size() > 1 ? rd_log[1].cyc : -1),
          128'(done_log.size() > 0 ? done_log[0] + 2 : -2));
    check("t1_finish_after_free", 128'(fin_cyc > free_edge[2]), 128'(1));
    check("t1_data_m1", d_m1, w0);
    check("t1_data_m2", d_m2, w1);
    check("t1_data_tpu", d_tpu, w2);
    stop();

    // Occupancy stall on back-to-back Mover1
    do_reset();
    flat[0] = 10;
    w0 = mk(4'h1, 1'b0); w1 = mk(4'h1, 1'b0);
    mem[8'h20] = w0; mem[8'h21] = w1; mem[8'h22] = mk(4'h0, 1'b0);
    push(0, w0); push(0, w1);
    start(8'h20);
    wait_finish("t2_finish", 300);
    d = drive_cyc(0, 0);
    d2 = drive_cyc(0, 1);
    check("t2_second_drive", 128'(d2), 128'(d + 11));
    nwin = 0;
    foreach (rd_log[j]) if (rd_log[j].cyc >= d + 2 && rd_log[j].cyc <= d + 11) nwin++;
    check("t2_no_fetch_in_stall", 128'(nwin), 128'(0));
    check("t2_cnt", 128'(cnt), 128'(2));
    flat[0] = 3;
    stop();

    // Barrier waits for the TPU to drain
    do_reset();
    flat[2] = 6;
    w0 = mk(4'h3, 1'b0); w1 = mk(4'h1, 1'b1);
    mem[8'h30] = w0; mem[8'h31] = w1; mem[8'h32] = mk(4'h0, 1'b0);
    push(2, w0); push(0, w1);
    start(8'h30);
    wait_finish("t3_finish", 300);
    t = free_edge[2];
    check("t3_barrier_drive", 128'(drive_cyc(0, 0)), 128'(t + 1));
    flat[2] = 3;
    stop();

    // Spurious free and illegal opcode
    do_reset();
    spur[1] = 1'b1;
    repeat (3) @(negedge clk);
    check("t4_spur_err", 128'(err), 128'(1));
    mem[8'h50] = mk(4'h5, 1'b0); mem[8'h51] = mk(4'h0, 1'b0);
    start(8'h50);
    wait_finish("t4_finish", 200);
    check("t4_err", 128'(err), 128'(1));
    check("t4_cnt", 128'(cnt), 128'(0));
    stop();
    check("t4_err_sticky", 128'(err), 128'(1));

    // Address wrap
    do_reset();
    mem[8'hFF] = mk(4'hF, 1'b0); mem[8'h00] = mk(4'h0, 1'b0);
    start(8'hFF);
    wait_finish("t5_finish", 200);
    check("t5_addr0", 128'(rd_log.size() > 0 ? rd_log[0].addr : 8'h5A), 128'(8'hFF));
    check("t5_addr1", 128'(rd_log.size() > 1 ? rd_log[1].addr : 8'h5A), 128'(8'h00));
    check("t5_err", 128'(err), 128'(0));
    stop();

    // Reset while a TPU instruction stalls in DISPATCH
    do_reset();
    auto_free[2] = 1'b0;
    w0 = mk(4'h3, 1'b0); w1 = mk(4'h3, 1'b0);
    mem[8'h40] = w0; mem[8'h41] = w1; mem[8'h42] = mk(4'h0, 1'b0);
    push(2, w0);
    start(8'h40);
    repeat (20) @(negedge clk);
    check("t6_one_drive", 128'(drv_log.size()), 128'(1));
    rst = 1'b1;
    can = 1'b0;
    @(negedge clk);
    check_reset("t6");
    rst = 1'b0;
    exp_q.delete(); drv_log.delete(); rd_log.delete(); done_log.delete();
    auto_free[2] = 1'b1;
    push(2, w1);
    start(8'h41);
    wait_finish("t6_restart_finish", 200);
    check("t6_cnt", 128'(cnt), 128'(1));
    check("t6_sb_empty", 128'(exp_q.size()), 128'(0));
    stop();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
